// File: rtl/audio_clk_pkg.sv
// Shared encodings and increment helper for the audio serial-clock generator.
package audio_clk_pkg;

    typedef enum logic {
        FMT_I2S = 1'b0,
        FMT_DSP = 1'b1
    } fmt_e;

    typedef enum logic [1:0] {
        RATE_48K  = 2'd0,
        RATE_44K1 = 2'd1,
        RATE_32K  = 2'd2,
        RATE_96K  = 2'd3
    } rate_e;

    localparam longint unsigned REF_HZ = 64'd50_000_000;

    // NCO increment: round(2 * fs * slots * bits / ref_hz * 2^acc_w).
    // The factor 2 is there because every carry toggles bclk (two carries per period).
    function automatic longint unsigned calc_inc(
        input longint unsigned fs_hz,
        input longint unsigned slots,
        input longint unsigned bits,
        input longint unsigned ref_hz,
        input int unsigned     acc_w
    );
        longint unsigned toggle_hz;
        toggle_hz = 64'd2 * fs_hz * slots * bits;
        return ((toggle_hz << acc_w) + (ref_hz >> 1)) / ref_hz;
    endfunction

endpackage

// File: rtl/audio_nco.sv
// Phase-accumulator NCO: every accumulator carry toggles the registered bclk.
module audio_nco
    import audio_clk_pkg::*;
#(
    parameter int unsigned ACC_W = 32
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic [ACC_W-1:0] inc,
    output logic             bclk,
    output logic             bclk_rise_stb,
    output logic             bclk_fall_stb,
    output logic             fall_evt
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             bclk_q, bclk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Next accumulator value, carry-driven toggle and edge strobes.
    always_comb begin
        sum    = {1'b0, acc_q} + {1'b0, inc};
        acc_d  = sum[ACC_W-1:0];
        carry  = sum[ACC_W];
        bclk_d = bclk_q ^ carry;
        rise_d = carry & ~bclk_q;
        fall_d = carry & bclk_q;
    end

    // Accumulator, bclk and strobes all update on the same edge.
    always_ff @(posedge refclk) begin
        if (rst) begin
            acc_q  <= '0;
            bclk_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            bclk_q <= bclk_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    // fall_evt lets the top update frame state on the same edge as bclk falls.
    assign fall_evt      = fall_d;
    assign bclk          = bclk_q;
    assign bclk_rise_stb = rise_q;
    assign bclk_fall_stb = fall_q;

endmodule

// File: rtl/audio_clk_gen.sv
// Audio BCLK/LRCLK generator: NCO bit clock, frame position, word select and lock tracking.
module audio_clk_gen
    import audio_clk_pkg::*;
#(
    parameter int unsigned      ACC_W       = 32,
    parameter int unsigned      NUM_SLOTS   = 2,
    parameter int unsigned      SLOT_BITS   = 32,
    parameter logic [ACC_W-1:0] INC_0       = ACC_W'(calc_inc(64'd48000, 64'(NUM_SLOTS), 64'(SLOT_BITS), REF_HZ, ACC_W)),
    parameter logic [ACC_W-1:0] INC_1       = ACC_W'(calc_inc(64'd44100, 64'(NUM_SLOTS), 64'(SLOT_BITS), REF_HZ, ACC_W)),
    parameter logic [ACC_W-1:0] INC_2       = ACC_W'(calc_inc(64'd32000, 64'(NUM_SLOTS), 64'(SLOT_BITS), REF_HZ, ACC_W)),
    parameter logic [ACC_W-1:0] INC_3       = ACC_W'(calc_inc(64'd96000, 64'(NUM_SLOTS), 64'(SLOT_BITS), REF_HZ, ACC_W)),
    parameter int unsigned      LOCK_FRAMES = 4
) (
    input  logic                         refclk,
    input  logic                         rst,
    input  logic [1:0]                   rate_sel,
    input  logic                         fmt,
    output logic                         bclk,
    output logic                         lrclk,
    output logic                         bclk_rise_stb,
    output logic                         bclk_fall_stb,
    output logic                         frame_stb,
    output logic [$clog2(NUM_SLOTS)-1:0] slot_idx,
    output logic [$clog2(SLOT_BITS)-1:0] bit_idx,
    output logic                         locked
);

    localparam int unsigned FRAME = NUM_SLOTS * SLOT_BITS;
    localparam int unsigned SW    = $clog2(NUM_SLOTS);
    localparam int unsigned BW    = $clog2(SLOT_BITS);
    localparam int unsigned PW    = $clog2(FRAME);
    localparam int unsigned LCW   = $clog2(LOCK_FRAMES + 1);

    localparam logic [SW-1:0]  SLOT_LAST = SW'(NUM_SLOTS - 1);
    localparam logic [BW-1:0]  BIT_LAST  = BW'(SLOT_BITS - 1);
    localparam logic [PW-1:0]  POS_LAST  = PW'(FRAME - 1);
    localparam logic [PW-1:0]  WS_LO     = PW'(FRAME / 2 - 1);
    localparam logic [PW-1:0]  WS_HI     = PW'(FRAME - 2);
    localparam logic [LCW-1:0] LOCK_MAX  = LCW'(LOCK_FRAMES);

    rate_e          rate_q, rate_d;
    fmt_e           fmt_q, fmt_d;
    rate_e          req_rate_q, req_rate_d;
    fmt_e           req_fmt_q, req_fmt_d;
    logic           pending_q, pending_d;
    logic [SW-1:0]  slot_q, slot_d;
    logic [BW-1:0]  bit_q, bit_d;
    logic           lrclk_q, lrclk_d;
    logic           frame_q, frame_d;
    logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
    logic           locked_q, locked_d;

    logic [ACC_W-1:0] inc_sel;
    logic             fall_evt;
    logic [PW-1:0]    pos_nxt;
    rate_e            tgt_rate;
    fmt_e             tgt_fmt;
    logic             change;

    // Increment for the currently active rate.
    always_comb begin
        case (rate_q)
            RATE_44K1: inc_sel = INC_1;
            RATE_32K:  inc_sel = INC_2;
            RATE_96K:  inc_sel = INC_3;
            default:   inc_sel = INC_0;
        endcase
    end

    audio_nco #(
        .ACC_W(ACC_W)
    ) u_nco (
        .refclk       (refclk),
        .rst          (rst),
        .inc          (inc_sel),
        .bclk         (bclk),
        .bclk_rise_stb(bclk_rise_stb),
        .bclk_fall_stb(bclk_fall_stb),
        .fall_evt     (fall_evt)
    );

    // Frame position, word select, deferred rate/format switch and lock counter.
    always_comb begin
        slot_d     = slot_q;
        bit_d      = bit_q;
        lrclk_d    = lrclk_q;
        frame_d    = 1'b0;
        pos_nxt    = '0;
        rate_d     = rate_q;
        fmt_d      = fmt_q;
        req_rate_d = req_rate_q;
        req_fmt_d  = req_fmt_q;
        pending_d  = pending_q;
        lock_cnt_d = lock_cnt_q;

        if (fall_evt) begin
            if (bit_q == BIT_LAST) begin
                bit_d  = '0;
                slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
            end else begin
                bit_d = bit_q + 1'b1;
            end
            pos_nxt = PW'(slot_d) * PW'(SLOT_BITS) + PW'(bit_d);
            frame_d = (pos_nxt == '0);
            if (fmt_q == FMT_DSP) begin
                lrclk_d = (pos_nxt == POS_LAST);
            end else begin
                lrclk_d = (pos_nxt >= WS_LO) && (pos_nxt <= WS_HI);
            end
        end

        // A change is measured against the most recent request, so only the latest one survives.
        tgt_rate = pending_q ? req_rate_q : rate_q;
        tgt_fmt  = pending_q ? req_fmt_q : fmt_q;
        change   = (rate_sel != tgt_rate) || (fmt != tgt_fmt);

        // Apply uses the pending state from before this edge, so a request seen on a frame edge waits one frame.
        if (frame_d) begin
            if (pending_q) begin
                rate_d    = req_rate_q;
                fmt_d     = req_fmt_q;
                pending_d = 1'b0;
            end else if (lock_cnt_q != LOCK_MAX) begin
                lock_cnt_d = lock_cnt_q + 1'b1;
            end
        end

        if (change) begin
            req_rate_d = rate_e'(rate_sel);
            req_fmt_d  = fmt_e'(fmt);
            pending_d  = 1'b1;
            lock_cnt_d = '0;
        end

        locked_d = !pending_d && (lock_cnt_d == LOCK_MAX);
    end

    // Frame/lock state registers; reset captures the requested rate and format.
    always_ff @(posedge refclk) begin
        if (rst) begin
            rate_q     <= rate_e'(rate_sel);
            fmt_q      <= fmt_e'(fmt);
            req_rate_q <= rate_e'(rate_sel);
            req_fmt_q  <= fmt_e'(fmt);
            pending_q  <= 1'b0;
            slot_q     <= '0;
            bit_q      <= '0;
            lrclk_q    <= 1'b0;
            frame_q    <= 1'b0;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            rate_q     <= rate_d;
            fmt_q      <= fmt_d;
            req_rate_q <= req_rate_d;
            req_fmt_q  <= req_fmt_d;
            pending_q  <= pending_d;
            slot_q     <= slot_d;
            bit_q      <= bit_d;
            lrclk_q    <= lrclk_d;
            frame_q    <= frame_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign lrclk     = lrclk_q;
    assign frame_stb = frame_q;
    assign slot_idx  = slot_q;
    assign bit_idx   = bit_q;
    assign locked    = locked_q;

endmodule

// File: doc/audio_clk_gen.md
Name: audio_clk_gen

Overview:
- Parametrised audio serial-clock generator, the next generation after the fixed 12.288 MHz audio PLL.
- Derives BCLK and LRCLK/frame-sync for I2S or TDM codecs from the 50 MHz board reference, using a fractional phase-accumulator (NCO).
- Supports selectable sample rate, slot count and slot width, and frame-aligned glitch-free rate switching.
- Exposes single-cycle strobes in the refclk domain so serialiser logic stays fully synchronous to refclk.

Parameters:
- ACC_W, 32: phase accumulator width.
- NUM_SLOTS, 2: channels (slots) per frame; even, 2..16.
- SLOT_BITS, 32: BCLK periods per slot; 16..32.
- INC_0, 527765581: phase increment, rate_sel=0 (48 kHz).
- INC_1, 484884628: phase increment, rate_sel=1 (44.1 kHz).
- INC_2, 351843721: phase increment, rate_sel=2 (32 kHz).
- INC_3, 1055531163: phase increment, rate_sel=3 (96 kHz).
- INC_n values are for 50 MHz ref, NUM_SLOTS=2, SLOT_BITS=32: INC = round(2·fs·NUM_SLOTS·SLOT_BITS / 50e6 · 2^ACC_W).
- LOCK_FRAMES, 4: complete frames after reset or rate change before locked asserts.

Ports:
- refclk, in, 1: single system clock (50 MHz).
- rst, in, 1: synchronous, active-high reset.
- rate_sel, in, 2: sample-rate select.
- fmt, in, 1: 0 = I2S, 1 = DSP/TDM one-bit frame sync.
- bclk, out, 1: serial bit clock, registered.
- lrclk, out, 1: word select (I2S) or frame-sync pulse (DSP), registered.
- bclk_rise_stb, out, 1: one-cycle pulse in the cycle bclk goes 0→1.
- bclk_fall_stb, out, 1: one-cycle pulse in the cycle bclk goes 1→0.
- frame_stb, out, 1: one-cycle pulse on the falling edge that starts pos 0.
- slot_idx, out, clog2(NUM_SLOTS): current slot.
- bit_idx, out, clog2(SLOT_BITS): current bit in slot, 0 = MSB.
- locked, out, 1: clocks valid at the selected rate/format.

Behaviour:
- Reset (synchronous, rst high at a refclk edge):
  - acc, bclk, lrclk, all strobes, slot_idx, bit_idx, locked, and the lock counter all go to 0.
  - rate_sel and fmt are captured into active registers.
  - Reset mid-frame aborts the frame immediately; no partial-frame completion.
- NCO: each cycle, {carry, acc} = acc + INC[active_rate] as an (ACC_W+1)-bit sum; carry=1 toggles bclk at that edge. Average bclk frequency = INC·50e6 / 2^(ACC_W+1). Jitter is one refclk period.
- Strobes: bclk_rise_stb / bclk_fall_stb are asserted in the same cycle the registered bclk changes. They are never both asserted.
- Position counter: pos = slot·SLOT_BITS + bit, advances on each bclk falling edge and wraps FRAME−1 → 0, where FRAME = NUM_SLOTS·SLOT_BITS. slot_idx/bit_idx are the decoded pos.
- frame_stb: pulses coincident with the bclk_fall_stb on which pos becomes 0.
- lrclk, updated only on bclk falls:
  - fmt=0 (I2S, WS leads MSB by one bit): lrclk=1 for pos in [FRAME/2−1, FRAME−2], else 0.
  - fmt=1 (DSP): lrclk=1 only when pos=FRAME−1, i.e. one bit before slot 0 MSB.
- Rate/format change:
  - A differing rate_sel/fmt sets pending and drops locked the next cycle.
  - The new values load into the active registers only at the next frame_stb; acc is not cleared, giving a continuous phase.
  - A further change while pending: the latest value wins and the lock counter restarts.
- Lock: the counter increments on each frame_stb with no pending change; locked=1 once the count reaches LOCK_FRAMES, then saturates. Any pending change clears both the counter and locked.
- Boundary cases:
  - A change arriving in the same cycle as frame_stb is applied at the following frame, not the current one.
  - rst wins over every other event.

Decomposition:
- Shared package audio_clk_pkg holds:
  - fmt encodings (FMT_I2S=0, FMT_DSP=1);
  - rate_sel encodings (RATE_48K, RATE_44K1, RATE_32K, RATE_96K);
  - the function that computes INC from fs, slots, bits and ref frequency.
- One natural sub-module, audio_nco: accumulator plus carry and bclk toggle, producing bclk and the rise/fall strobes. Frame counting, lrclk and lock logic stay in the top level.

Test Plan:
- Reset release, rate_sel=0, fmt=0 → first bclk rise and bclk_rise_stb 9 cycles after rst deasserts; no carry in the first 8 cycles.
- 48 kHz, 5,000,000 cycles → 307,200 ±1 bclk_rise_stb and 4,800 ±1 frame_stb; bclk high/low durations differ by at most 1 cycle.
- fmt=0 over one frame → lrclk rises on the fall into pos 31, falls on the fall into pos 63; fmt=1 → single-bit lrclk pulse at pos 63.
- Switch rate_sel 0→1 mid-frame (pos 20) → locked=0 next cycle; increment changes at the next frame_stb; locked=1 at the 4th following frame_stb; 44.1 kHz frame rate ±1.
- Change rate_sel twice within one frame (0→3→2) → only 32 kHz applied at the boundary; the lock count restarts at the second change.
- Assert rst at pos 40 → all outputs 0 on the next cycle; after release the sequence repeats the first-scenario timing exactly.
